// File: rtl/fc_ctrl_pkg.sv
// Shared definitions for the ping-pong fully-connected layer controller.
// Holds the compute-state encoding, the default layer geometry, the address
// widths that follow from it, and a counter-width helper.
package fc_ctrl_pkg;

    localparam int FC_M      = 8;   // output rows
    localparam int FC_N      = 8;   // input vector length
    localparam int FC_RD_LAT = 1;   // address-to-operand latency

    localparam int AW_X = $clog2(FC_N);         // vector-memory address within a bank
    localparam int AW_W = $clog2(FC_M * FC_N);  // weight-ROM address

    typedef enum logic [1:0] {
        C_IDLE,
        C_MAC,
        C_DRAIN,
        C_OUT
    } c_state_t;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_bank_tracker.sv
// Loader side of the two-bank vector memory.
// Streams incoming words into the bank selected by wr_buf, marks a bank full
// once N words have landed, and flips to the other bank. A bank is released
// by the compute side via release_bank/release_buf once its last row is out.
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   input_valid        upstream word valid
//   release_bank       compute side is done with bank release_buf
//   release_buf        bank being released
//   input_ready        registered: current write bank is free
//   wr_en_x            write strobe (input_valid & input_ready)
//   wr_buf, wr_addr_x  bank and address of the word being written
//   full               per-bank full flags
module fc_bank_tracker
    import fc_ctrl_pkg::*;
#(
    parameter int N = FC_N
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 input_valid,
    input  logic                 release_bank,
    input  logic                 release_buf,
    output logic                 input_ready,
    output logic                 wr_en_x,
    output logic                 wr_buf,
    output logic [$clog2(N)-1:0] wr_addr_x,
    output logic [1:0]           full
);

    localparam int XW = $clog2(N);

    logic [1:0]    full_nxt;
    logic          wr_buf_nxt;
    logic [XW-1:0] wr_addr_nxt;

    assign wr_en_x = input_valid & input_ready;

    // Release and fill always target different banks (the write bank can only
    // equal the read bank while that bank is empty), so both edits may land
    // in the same cycle.
    always_comb begin
        full_nxt    = full;
        wr_buf_nxt  = wr_buf;
        wr_addr_nxt = wr_addr_x;
        if (release_bank)
            full_nxt[release_buf] = 1'b0;
        if (wr_en_x) begin
            if (wr_addr_x == XW'(N - 1)) begin
                full_nxt[wr_buf] = 1'b1;
                wr_buf_nxt       = ~wr_buf;
                wr_addr_nxt      = '0;
            end else begin
                wr_addr_nxt = wr_addr_x + XW'(1);
            end
        end
    end

    // input_ready is computed from next-state values so it tracks
    // ~full[wr_buf] exactly while still being a flop (0 during reset).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full        <= '0;
            wr_buf      <= 1'b0;
            wr_addr_x   <= '0;
            input_ready <= 1'b0;
        end else begin
            full        <= full_nxt;
            wr_buf      <= wr_buf_nxt;
            wr_addr_x   <= wr_addr_nxt;
            input_ready <= ~full_nxt[wr_buf_nxt];
        end
    end

endmodule

// File: rtl/fc_pingpong_ctrl.sv
// Control sequencer for the fully-connected layer y = W*x with a ping-pong
// vector memory: bank k+1 fills while bank k is multiplied row by row.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   input_valid/input_ready    upstream word handshake
//   wr_en_x, wr_buf, wr_addr_x vector-memory write port
//   rd_buf, rd_addr_x          vector-memory read port
//   addr_w                     weight-ROM address
//   clear_acc, en_acc          accumulator control
//   output_valid/output_ready  row-result handshake
//   busy                       compute FSM active
module fc_pingpong_ctrl
    import fc_ctrl_pkg::*;
#(
    parameter int M      = FC_M,
    parameter int N      = FC_N,
    parameter int RD_LAT = FC_RD_LAT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   input_valid,
    output logic                   input_ready,
    output logic                   wr_en_x,
    output logic                   wr_buf,
    output logic [$clog2(N)-1:0]   wr_addr_x,
    output logic                   rd_buf,
    output logic [$clog2(N)-1:0]   rd_addr_x,
    output logic [$clog2(M*N)-1:0] addr_w,
    output logic                   clear_acc,
    output logic                   en_acc,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic                   busy
);

    localparam int XW = $clog2(N);
    localparam int WW = $clog2(M * N);
    localparam int RW = cnt_w(M);
    localparam int DW = cnt_w(RD_LAT);

    c_state_t      state, state_nxt;
    logic [RW-1:0] row, row_nxt;
    logic [DW-1:0] drain, drain_nxt;
    logic [XW-1:0] rd_addr_nxt;
    logic [WW-1:0] addr_w_nxt;
    logic          rd_buf_nxt, clear_nxt, ov_nxt, issue_nxt;
    logic          release_bank;
    logic [1:0]    full;

    // vld_pipe[0] is the registered address-issue strobe; operands for that
    // address arrive RD_LAT cycles later, which is when they are accumulated.
    logic [RD_LAT:0] vld_pipe;

    fc_bank_tracker #(.N(N)) u_bank (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .release_bank (release_bank),
        .release_buf  (rd_buf),
        .input_ready  (input_ready),
        .wr_en_x      (wr_en_x),
        .wr_buf       (wr_buf),
        .wr_addr_x    (wr_addr_x),
        .full         (full)
    );

    assign busy   = (state != C_IDLE);
    assign en_acc = vld_pipe[RD_LAT];

    // rd_addr_x doubles as the column counter. addr_w simply increments with
    // every issued address, so row*N+col is never multiplied out.
    always_comb begin
        state_nxt    = state;
        row_nxt      = row;
        drain_nxt    = drain;
        rd_addr_nxt  = rd_addr_x;
        addr_w_nxt   = addr_w;
        rd_buf_nxt   = rd_buf;
        clear_nxt    = 1'b0;
        ov_nxt       = 1'b0;
        issue_nxt    = 1'b0;
        release_bank = 1'b0;
        case (state)
            C_IDLE: begin
                if (full[rd_buf]) begin
                    state_nxt   = C_MAC;
                    row_nxt     = '0;
                    rd_addr_nxt = '0;
                    addr_w_nxt  = '0;
                    clear_nxt   = 1'b1;
                    issue_nxt   = 1'b1;
                end
            end
            C_MAC: begin
                if (rd_addr_x == XW'(N - 1)) begin
                    state_nxt = C_DRAIN;
                    drain_nxt = '0;
                end else begin
                    rd_addr_nxt = rd_addr_x + XW'(1);
                    addr_w_nxt  = addr_w + WW'(1);
                    issue_nxt   = 1'b1;
                end
            end
            C_DRAIN: begin
                if (drain == DW'(RD_LAT - 1)) begin
                    state_nxt = C_OUT;
                    ov_nxt    = 1'b1;
                end else begin
                    drain_nxt = drain + DW'(1);
                end
            end
            C_OUT: begin
                ov_nxt = 1'b1;
                if (output_ready) begin
                    ov_nxt = 1'b0;
                    if (row == RW'(M - 1)) begin
                        // Last row of this vector: hand the bank back.
                        release_bank = 1'b1;
                        rd_buf_nxt   = ~rd_buf;
                        rd_addr_nxt  = '0;
                        addr_w_nxt   = '0;
                        state_nxt    = C_IDLE;
                    end else begin
                        row_nxt     = row + RW'(1);
                        rd_addr_nxt = '0;
                        addr_w_nxt  = addr_w + WW'(1);
                        clear_nxt   = 1'b1;
                        issue_nxt   = 1'b1;
                        state_nxt   = C_MAC;
                    end
                end
            end
            default: state_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= C_IDLE;
            row          <= '0;
            drain        <= '0;
            rd_addr_x    <= '0;
            addr_w       <= '0;
            rd_buf       <= 1'b0;
            clear_acc    <= 1'b0;
            output_valid <= 1'b0;
            vld_pipe     <= '0;
        end else begin
            state        <= state_nxt;
            row          <= row_nxt;
            drain        <= drain_nxt;
            rd_addr_x    <= rd_addr_nxt;
            addr_w       <= addr_w_nxt;
            rd_buf       <= rd_buf_nxt;
            clear_acc    <= clear_nxt;
            output_valid <= ov_nxt;
            vld_pipe     <= {vld_pipe[RD_LAT-1:0], issue_nxt};
        end
    end

endmodule

// File: tb/tb_fc_pingpong_ctrl.sv
// Bench for fc_pingpong_ctrl (M=N=8, RD_LAT=1). A behavioural vector memory,
// weight ROM and accumulator are driven by the controller outputs; expected
// dot products are queued when a vector is sent and popped on each result
// handshake.
module tb_fc_pingpong_ctrl;
    import fc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic input_valid, input_ready, wr_en_x, wr_buf, rd_buf;
    logic [AW_X-1:0] wr_addr_x, rd_addr_x;
    logic [AW_W-1:0] addr_w;
    logic clear_acc, en_acc, output_valid, output_ready, busy;

    logic [7:0]  in_data;
    logic [7:0]  xv  [FC_N];
    logic [7:0]  rom [FC_M*FC_N];
    logic [7:0]  mem [2*FC_N];
    logic [7:0]  xq, wq;
    logic [31:0] acc;
    logic [31:0] exp_q [$];
    int tests = 0;
    int fails = 0;

    logic [19:0] outs;
    assign outs = {input_ready, wr_en_x, wr_buf, wr_addr_x, rd_buf, rd_addr_x,
                   addr_w, clear_acc, en_acc, output_valid, busy};

    always #5 clk = ~clk;

    fc_pingpong_ctrl #(.M(FC_M), .N(FC_N), .RD_LAT(FC_RD_LAT)) dut (
        .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(input_ready),
        .wr_en_x(wr_en_x), .wr_buf(wr_buf), .wr_addr_x(wr_addr_x), .rd_buf(rd_buf),
        .rd_addr_x(rd_addr_x), .addr_w(addr_w), .clear_acc(clear_acc), .en_acc(en_acc),
        .output_valid(output_valid), .output_ready(output_ready), .busy(busy)
    );

    // Datapath model: memory/ROM read with one cycle latency, accumulator.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= 0; xq <= 0; wq <= 0;
        end else begin
            if (wr_en_x) mem[{wr_buf, wr_addr_x}] <= in_data;
            xq <= mem[{rd_buf, rd_addr_x}];
            wq <= rom[addr_w];
            if (clear_acc) acc <= 0;
            else if (en_acc) acc <= acc + 32'(xq) * 32'(wq);
        end
    end

    function automatic logic [31:0] dot(input int r);
        logic [31:0] s = 0;
        for (int c = 0; c < FC_N; c++) s += 32'(xv[c]) * 32'(rom[r*FC_N + c]);
        return s;
    endfunction

    task automatic rand_vec();
        for (int i = 0; i < FC_N; i++) xv[i] = 8'($urandom);
    endtask

    task automatic sb_monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset && output_valid && output_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_extra: result %0d produced, none expected", acc);
                end else begin
                    e = exp_q.pop_front();
                    if (acc !== e) begin
                        fails++;
                        $display("FAIL sb_result: acc=%0d, required %0d", acc, e);
                    end
                end
            end
        end
    endtask

    // Sends xv as one vector; entry/exit aligned 1 time unit after posedge.
    task automatic send_vec(input int gap_pct);
        for (int r = 0; r < FC_M; r++) exp_q.push_back(dot(r));
        for (int i = 0; i < FC_N; i++) begin
            int guard;
            bit took;
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                input_valid = 1'b0; @(posedge clk); #1;
            end
            input_valid = 1'b1; in_data = xv[i]; took = 1'b0; guard = 0;
            while (!took) begin
                @(negedge clk); took = input_ready;
                @(posedge clk); #1;
                guard++;
                if (!took && guard > 600) begin
                    tests++; fails++;
                    $display("FAIL send_timeout word %0d: input_ready=0, required 1", i);
                    input_valid = 1'b0;
                    return;
                end
            end
        end
        input_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; input_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; input_valid = 1'b0; output_ready = 1'b0; in_data = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); tests++;
            if (outs !== 20'd0) begin fails++; $display("FAIL reset_outs: %h, required 0", outs); end
        end
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk); tests++;
        if (input_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_early: %b, required 0", input_ready); end
        @(posedge clk); #1;
        @(negedge clk); tests++;
        if ({input_ready, busy} !== 2'b10) begin
            fails++; $display("FAIL reset_release: ready,busy=%b, required 10", {input_ready, busy});
        end
        @(posedge clk); #1;
    endtask

    // Cycle-exact trace of one vector with output_ready held high.
    task automatic test_single();
        logic [19:0] ex;
        logic [AW_X-1:0] ra;
        logic [AW_W-1:0] aw;
        logic ce, ee, ov, by;
        bit ok;
        output_ready = 1'b1;
        rand_vec();
        for (int r = 0; r < FC_M; r++) exp_q.push_back(dot(r));
        for (int k = 0; k < 95; k++) begin
            int m;
            input_valid = (k < FC_N); in_data = xv[k % FC_N];
            m = k - 9; ce = 0; ee = 0; ov = 0; by = 0; aw = '0; ra = '0;
            if (m >= 0 && m < 80) begin
                int r, p;
                r = m / 10; p = m % 10; by = 1;
                ce = (p == 0); ee = (p >= 1 && p <= 8); ov = (p == 9);
                ra = (p < 8) ? AW_X'(p) : AW_X'(7);
                aw = AW_W'(r * 8) + ((p < 8) ? AW_W'(p) : AW_W'(7));
            end
            ex = {1'b1, k < 8, k >= 8, (k < 8) ? AW_X'(k) : AW_X'(0), k >= 89, ra, aw, ce, ee, ov, by};
            @(negedge clk); tests++;
            if (outs !== ex) begin
                fails++; $display("FAIL single_cycle%0d: outs=%h, required %h", k, outs, ex);
            end
            @(posedge clk); #1;
        end
        input_valid = 1'b0;
        wait_idle(ok); tests++;
        if (!ok) begin fails++; $display("FAIL single_drain: queue=%0d busy=%b, required 0/0", exp_q.size(), busy); end
    endtask

    task automatic test_backpressure();
        logic [AW_W-1:0] aw;
        logic [AW_X-1:0] ra;
        bit seen, ok;
        output_ready = 1'b0;
        rand_vec();
        send_vec(0);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk); seen = output_valid;
            if (!seen) begin @(posedge clk); #1; end
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL bp_no_output: output_valid=0, required 1"); end
        aw = addr_w; ra = rd_addr_x;
        tests++;
        if ({aw, ra} !== {AW_W'(7), AW_X'(7)}) begin
            fails++; $display("FAIL bp_addr_row0: addr_w=%0d rd_addr_x=%0d, required 7/7", aw, ra);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk); tests++;
            if ({output_valid, en_acc, addr_w, rd_addr_x} !== {1'b1, 1'b0, aw, ra}) begin
                fails++;
                $display("FAIL bp_hold%0d: ov=%b en=%b addr_w=%0d rd=%0d, required 1 0 %0d %0d",
                         i, output_valid, en_acc, addr_w, rd_addr_x, aw, ra);
            end
        end
        @(posedge clk); #1; output_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); tests++;
        if ({clear_acc, addr_w, rd_addr_x} !== {1'b1, aw + AW_W'(1), AW_X'(0)}) begin
            fails++;
            $display("FAIL bp_resume: clear=%b addr_w=%0d rd=%0d, required 1 %0d 0",
                     clear_acc, addr_w, rd_addr_x, aw + AW_W'(1));
        end
        @(posedge clk); #1;
        wait_idle(ok); tests++;
        if (!ok) begin fails++; $display("FAIL bp_drain: queue=%0d busy=%b, required 0/0", exp_q.size(), busy); end
    endtask

    task automatic test_overlap();
        int accepts, toggles;
        logic last_rd;
        logic [2:0] seq;
        bit ok;
        do_reset();
        output_ready = 1'b1;
        accepts = 0; toggles = 0; last_rd = 1'b0; seq = '0;
        fork
            begin
                for (int v = 0; v < 3; v++) begin rand_vec(); send_vec(0); end
            end
            begin
                for (int i = 0; i < 1000 && toggles < 3; i++) begin
                    @(negedge clk);
                    if (rd_buf !== last_rd) begin
                        if (toggles == 0) begin
                            tests++;
                            if (accepts != 16) begin
                                fails++; $display("FAIL overlap_accepts: %0d before release, required 16", accepts);
                            end
                        end
                        seq[toggles] = rd_buf; toggles++; last_rd = rd_buf;
                    end
                    if (wr_en_x) begin
                        if (accepts == 16) begin
                            tests++;
                            if (wr_buf !== 1'b0) begin
                                fails++; $display("FAIL overlap_third_bank: wr_buf=%b, required 0", wr_buf);
                            end
                        end
                        accepts++;
                    end
                end
            end
        join
        #1;
        tests++;
        if ({toggles[1:0], seq} !== {2'd3, 3'b101}) begin
            fails++; $display("FAIL overlap_rd_seq: toggles=%0d seq=%b, required 3 101", toggles, seq);
        end
        wait_idle(ok); tests++;
        if (!ok) begin fails++; $display("FAIL overlap_drain: queue=%0d busy=%b, required 0/0", exp_q.size(), busy); end
    endtask

    task automatic test_golden();
        bit fin, ok;
        fin = 0; ok = 0;
        fork
            begin
                for (int v = 0; v < 20; v++) begin rand_vec(); send_vec(30); end
                wait_idle(ok);
                fin = 1;
            end
            begin
                while (!fin) begin
                    output_ready = ($urandom_range(2) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        output_ready = 1'b1;
        tests++;
        if (!ok) begin fails++; $display("FAIL golden_drain: queue=%0d busy=%b, required 0/0", exp_q.size(), busy); end
    endtask

    task automatic test_reset_mid();
        bit hit, ok;
        output_ready = 1'b1;
        rand_vec();
        send_vec(0);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = busy && addr_w == AW_W'(28) && rd_addr_x == AW_X'(4);
            if (!hit) begin @(posedge clk); #1; end
        end
        tests++;
        if (!hit) begin fails++; $display("FAIL rmid_no_trigger: row3/col4 not reached, required reached"); end
        reset = 1'b0;
        exp_q.delete();
        #1; tests++;
        if (outs !== 20'd0) begin fails++; $display("FAIL rmid_outs: %h, required 0", outs); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); tests++;
        if ({input_ready, wr_buf, addr_w, busy} !== {1'b1, 1'b0, AW_W'(0), 1'b0}) begin
            fails++;
            $display("FAIL rmid_after: ready=%b wr_buf=%b addr_w=%0d busy=%b, required 1 0 0 0",
                     input_ready, wr_buf, addr_w, busy);
        end
        @(posedge clk); #1;
        rand_vec();
        send_vec(0);
        wait_idle(ok); tests++;
        if (!ok) begin fails++; $display("FAIL rmid_drain: queue=%0d busy=%b, required 0/0", exp_q.size(), busy); end
    endtask

    initial begin
        for (int i = 0; i < FC_M*FC_N; i++) rom[i] = 8'($urandom);
        fork sb_monitor(); join_none
        test_reset();
        test_single();
        test_backpressure();
        test_overlap();
        test_golden();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
